alu_ctrl_issue: RTL and testbench
=================================

ALU_CTRL_ISSUE -- requirements
Module: alu_ctrl_issue

Interface
REQ-001 The block SHALL have parameter OPW, default 11, giving the instruction opcode width in bits.
REQ-002 The block SHALL have parameter CW, default 8, giving the illegal-op counter width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream decode stage offers an op.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an op this cycle.
REQ-007 The block SHALL have port ALUOp, input, 2 bits: the main-decoder ALU class.
REQ-008 The block SHALL have port opcode, input, OPW bits: the instruction opcode field.
REQ-009 The block SHALL have port flush, input, 1 bit: discard all buffered ops.
REQ-010 The block SHALL have port out_valid, output, 1 bit: ALUControl is valid for the ALU.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the execute stage consumes the op.
REQ-012 The block SHALL have port ALUControl, output, 4 bits: the ALU operation select.
REQ-013 The block SHALL have port illegal, output, 1 bit: the head op failed to decode.
REQ-014 The block SHALL have port illegal_cnt, output, CW bits: saturating count of illegal ops accepted.

Function
REQ-015 An op SHALL be accepted when in_valid and in_ready are both 1 at a rising edge, and SHALL be consumed when out_valid and out_ready are both 1.
REQ-016 Decode SHALL be:
  - ALUOp 00: ALUControl 0010 (add, load/store).
  - ALUOp 01: ALUControl 0111 (pass b, CBZ).
  - ALUOp 10 with opcode 10001011000: 0010 (ADD).
  - ALUOp 10 with opcode 11001011000: 0110 (SUB).
  - ALUOp 10 with opcode 10001010000: 0000 (AND).
  - ALUOp 10 with opcode 10101010000: 0001 (ORR).
  - ALUOp 10 with any other opcode, or ALUOp 11: ALUControl 1111, illegal 1.
REQ-017 Decode SHALL happen at acceptance; the buffer SHALL store only ALUControl (4 bits) and illegal (1 bit) per entry.
REQ-018 The buffer SHALL be a 2-entry in-order FIFO with occupancy count 0..2.
REQ-019 in_ready SHALL be 1 exactly when occupancy is below 2, and SHALL be a function of registered state only.
REQ-020 out_valid SHALL be 1 exactly when occupancy is above 0; ALUControl and illegal SHALL show the head entry.
REQ-021 Latency SHALL be 1 cycle: an op accepted into an empty buffer at edge N SHALL appear with out_valid 1 after edge N.
REQ-022 When a push and a pop occur together, occupancy SHALL be unchanged and order SHALL be preserved; at occupancy 1 the new op SHALL become head on the next cycle.
REQ-023 At occupancy 2 no push SHALL occur; a pop SHALL make in_ready 1 on the next cycle.
REQ-024 When occupancy is 0, ALUControl SHALL be 1111 and illegal SHALL be 0.
REQ-025 Head outputs SHALL remain stable while out_valid is 1 and out_ready is 0.
REQ-026 flush SHALL set occupancy to 0 at the next edge and SHALL override any same-cycle push or pop.
REQ-027 A flushed illegal op SHALL still have been counted.
REQ-028 illegal_cnt SHALL increment by 1 on each accepted op that decodes illegal, SHALL saturate at 2^CW-1, and SHALL NOT be cleared by flush.

Reset
REQ-029 Asserting reset (low) SHALL immediately, without a clock edge, set occupancy to 0, illegal_cnt to 0, out_valid to 0, in_ready to 1, ALUControl to 1111, and illegal to 0.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered ops; no op SHALL be output after release until a new op is accepted.
REQ-031 The first acceptance SHALL occur no earlier than the first rising edge after reset deasserts.

Structure
REQ-032 A shared package SHALL hold the ALUControl constants (AND 0000, ORR 0001, ADD 0010, SUB 0110, PASSB 0111, NOR 1100, ILL 1111), the four R-type opcode constants, and the ALUOp class encodings.
REQ-033 The combinational decode SHALL be a sub-module named alu_ctrl_decode; the FIFO and counter SHALL live in alu_ctrl_issue.

Verification
REQ-034 Reset scenario: after reset, in_valid 1, ALUOp 10, opcode 11001011000, out_ready 1 -> next cycle out_valid 1, ALUControl 0110, illegal 0.
REQ-035 Backpressure scenario: with out_ready 0, push ADD, AND, ORR -> in_ready 0 after the 2nd push, the ORR is not accepted, and the head stays 0010; then out_ready 1 -> 0010 then 0000 in order.
REQ-036 Illegal scenario: push ALUOp 11, then ALUOp 10 with opcode 0 -> ALUControl 1111, illegal 1 for both, illegal_cnt 2.
REQ-037 Saturation scenario: with CW 2, accept 5 illegal ops -> illegal_cnt 3.
REQ-038 Flush scenario: at occupancy 2, flush 1 with in_valid 1 and out_ready 1 -> next cycle out_valid 0, in_ready 1, illegal_cnt unchanged.
REQ-039 Async reset scenario: at occupancy 2, pulse reset low between edges -> out_valid 0 and ALUControl 1111 immediately, before the next edge.

Source files
------------

// File: rtl/alu_ctrl_issue_pkg.sv
// alu_ctrl_issue_pkg: ALU control encodings, R-type opcodes and ALUOp classes
// shared by the decoder and the issue buffer.
package alu_ctrl_issue_pkg;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_ILL   = 4'b1111;
    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [1:0] AOP_MEM = 2'b00;
    localparam logic [1:0] AOP_CBZ = 2'b01;
    localparam logic [1:0] AOP_R   = 2'b10;
    localparam logic [1:0] AOP_ILL = 2'b11;
    typedef struct packed {
        logic [3:0] ctrl;
        logic       ill;
    } entry_t;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALUOp/opcode to ALU control decode.
module alu_ctrl_decode
    import alu_ctrl_issue_pkg::*;
#(
    parameter int OPW = 11
) (
    input  logic [1:0]     ALUOp,
    input  logic [OPW-1:0] opcode,
    output entry_t         dec
);
    logic [3:0] r_ctrl;
    logic [3:0] ctrl;
    always_comb begin
        r_ctrl = opcode == OPW'(OP_ADD) ? ALU_ADD :
                 opcode == OPW'(OP_SUB) ? ALU_SUB :
                 opcode == OPW'(OP_AND) ? ALU_AND :
                 opcode == OPW'(OP_ORR) ? ALU_ORR : ALU_ILL;
        ctrl = ALUOp == AOP_MEM ? ALU_ADD :
               ALUOp == AOP_CBZ ? ALU_PASSB :
               ALUOp == AOP_R   ? r_ctrl : ALU_ILL;
        dec = '{ctrl: ctrl, ill: ctrl == ALU_ILL};
    end
endmodule

// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: decodes ops at acceptance into a 2-entry in-order buffer
// and keeps a saturating count of illegal ops accepted.
module alu_ctrl_issue
    import alu_ctrl_issue_pkg::*;
#(
    parameter int OPW = 11,
    parameter int CW  = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     ALUOp,
    input  logic [OPW-1:0] opcode,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [3:0]     ALUControl,
    output logic           illegal,
    output logic [CW-1:0]  illegal_cnt
);
    entry_t     mem [2];
    entry_t     dec;
    entry_t     head;
    logic [1:0] cnt;
    logic       rp;
    logic       wp;
    logic       push;
    logic       pop;

    alu_ctrl_decode #(.OPW(OPW)) u_dec (
        .ALUOp (ALUOp),
        .opcode(opcode),
        .dec   (dec)
    );

    assign in_ready   = cnt != 2'd2;
    assign out_valid  = cnt != 2'd0;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign head       = mem[rp];
    assign ALUControl = out_valid ? head.ctrl : ALU_ILL;
    assign illegal    = out_valid && head.ill;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= dec;
    end

    // Counting happens at acceptance, so a later (or same-cycle) flush keeps it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= 2'd0;
            rp          <= 1'b0;
            wp          <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            if (flush) begin
                cnt <= 2'd0;
                rp  <= 1'b0;
                wp  <= 1'b0;
            end else begin
                if (push) wp <= ~wp;
                if (pop) rp <= ~rp;
                cnt <= cnt + 2'(push) - 2'(pop);
            end
            if (push && dec.ill && illegal_cnt != {CW{1'b1}}) illegal_cnt <= illegal_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb_alu_ctrl_issue: table vectors, directed corner sequences and random
// traffic checked against a queue-based reference model.
module tb_alu_ctrl_issue;
    localparam logic [10:0] T_ADD = 11'b10001011000;
    localparam logic [10:0] T_SUB = 11'b11001011000;
    localparam logic [10:0] T_AND = 11'b10001010000;
    localparam logic [10:0] T_ORR = 11'b10101010000;

    typedef struct packed {
        logic [3:0] c;
        logic       i;
    } ent_t;

    typedef struct packed {
        logic [1:0]  ao;
        logic [10:0] op;
        logic [3:0]  ec;
        logic        ei;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  ALUOp = 2'b00;
    logic [10:0] opcode = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, illegal;
    logic [3:0]  ALUControl;
    logic [7:0]  illegal_cnt;
    logic        in_ready2, out_valid2, illegal2;
    logic [3:0]  ALUControl2;
    logic [1:0]  illegal_cnt2;

    int checks = 0;
    int failures = 0;
    ent_t q[$];
    int mc = 0;
    int mc2 = 0;

    alu_ctrl_issue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .opcode(opcode), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .ALUControl(ALUControl), .illegal(illegal),
        .illegal_cnt(illegal_cnt)
    );

    alu_ctrl_issue #(.OPW(11), .CW(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .ALUOp(ALUOp), .opcode(opcode), .flush(flush), .out_valid(out_valid2),
        .out_ready(out_ready), .ALUControl(ALUControl2), .illegal(illegal2),
        .illegal_cnt(illegal_cnt2)
    );

    always #5 clk = ~clk;

    function automatic ent_t ref_dec(input logic [1:0] ao, input logic [10:0] op);
        if (ao == 2'b00) return '{c: 4'b0010, i: 1'b0};
        if (ao == 2'b01) return '{c: 4'b0111, i: 1'b0};
        if (ao == 2'b10 && op == T_ADD) return '{c: 4'b0010, i: 1'b0};
        if (ao == 2'b10 && op == T_SUB) return '{c: 4'b0110, i: 1'b0};
        if (ao == 2'b10 && op == T_AND) return '{c: 4'b0000, i: 1'b0};
        if (ao == 2'b10 && op == T_ORR) return '{c: 4'b0001, i: 1'b0};
        return '{c: 4'b1111, i: 1'b1};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [3:0] ec;
        logic       ei;
        ec = q.size() > 0 ? q[0].c : 4'b1111;
        ei = q.size() > 0 ? q[0].i : 1'b0;
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("ALUControl", 32'(ALUControl), 32'(ec));
        chk("illegal", 32'(illegal), 32'(ei));
        chk("illegal_cnt", 32'(illegal_cnt), 32'(mc));
        chk("out_valid_cw2", 32'(out_valid2), 32'(q.size() > 0));
        chk("in_ready_cw2", 32'(in_ready2), 32'(q.size() < 2));
        chk("ALUControl_cw2", 32'(ALUControl2), 32'(ec));
        chk("illegal_cw2", 32'(illegal2), 32'(ei));
        chk("illegal_cnt_cw2", 32'(illegal_cnt2), 32'(mc2));
    endtask

    task automatic cycle(input logic iv, input logic [1:0] ao, input logic [10:0] op,
                         input logic fl, input logic ordy);
        logic acc, con;
        ent_t e;
        in_valid = iv; ALUOp = ao; opcode = op; flush = fl; out_ready = ordy;
        acc = iv && q.size() < 2;
        con = q.size() > 0 && ordy;
        e = ref_dec(ao, op);
        @(posedge clk);
        #1;
        if (acc && e.i) begin
            if (mc < 255) mc++;
            if (mc2 < 3) mc2++;
        end
        if (fl) q.delete();
        else begin
            if (con) q.delete(0);
            if (acc) q.push_back(e);
        end
        model_check();
    endtask

    // Reset is applied mid-cycle and checked before any edge; an offered op
    // during reset must not be accepted.
    task automatic do_reset();
        in_valid = 1'b1; ALUOp = 2'b00; flush = 1'b0; out_ready = 1'b0;
        reset = 1'b0;
        #1;
        q.delete(); mc = 0; mc2 = 0;
        model_check();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        model_check();
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{ao: 2'b00, op: 11'h5a5, ec: 4'b0010, ei: 1'b0};
        vecs[1] = '{ao: 2'b01, op: 11'h000, ec: 4'b0111, ei: 1'b0};
        vecs[2] = '{ao: 2'b10, op: T_ADD, ec: 4'b0010, ei: 1'b0};
        vecs[3] = '{ao: 2'b10, op: T_SUB, ec: 4'b0110, ei: 1'b0};
        vecs[4] = '{ao: 2'b10, op: T_AND, ec: 4'b0000, ei: 1'b0};
        vecs[5] = '{ao: 2'b10, op: T_ORR, ec: 4'b0001, ei: 1'b0};
        vecs[6] = '{ao: 2'b10, op: 11'b11001011001, ec: 4'b1111, ei: 1'b1};
        vecs[7] = '{ao: 2'b11, op: T_ADD, ec: 4'b1111, ei: 1'b1};

        do_reset();
        cycle(1'b1, 2'b10, T_SUB, 1'b0, 1'b1);
        chk("rst_seq_valid", 32'(out_valid), 32'd1);
        chk("rst_seq_ctrl", 32'(ALUControl), 32'h6);
        chk("rst_seq_ill", 32'(illegal), 32'd0);

        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, vecs[k].ao, vecs[k].op, 1'b0, 1'b1);
            chk("vec_ctrl", 32'(ALUControl), 32'(vecs[k].ec));
            chk("vec_ill", 32'(illegal), 32'(vecs[k].ei));
        end

        do_reset();
        cycle(1'b1, 2'b10, T_ADD, 1'b0, 1'b0);
        cycle(1'b1, 2'b10, T_AND, 1'b0, 1'b0);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 2'b10, T_ORR, 1'b0, 1'b0);
        chk("bp_head_hold", 32'(ALUControl), 32'h2);
        cycle(1'b0, 2'b10, T_ORR, 1'b0, 1'b1);
        chk("bp_second", 32'(ALUControl), 32'h0);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        cycle(1'b0, 2'b10, T_ORR, 1'b0, 1'b1);
        chk("bp_empty", 32'(out_valid), 32'd0);

        do_reset();
        cycle(1'b1, 2'b11, 11'h000, 1'b0, 1'b0);
        cycle(1'b1, 2'b10, 11'h000, 1'b0, 1'b0);
        chk("ill_first", 32'({ALUControl, illegal}), 32'h1f);
        cycle(1'b0, 2'b00, 11'h000, 1'b0, 1'b1);
        chk("ill_second", 32'({ALUControl, illegal}), 32'h1f);
        chk("ill_cnt", 32'(illegal_cnt), 32'd2);

        do_reset();
        for (int k = 0; k < 5; k++) cycle(1'b1, 2'b11, 11'h000, 1'b0, 1'b1);
        chk("sat_cw2", 32'(illegal_cnt2), 32'd3);
        chk("sat_cw8", 32'(illegal_cnt), 32'd5);

        cycle(1'b0, 2'b00, 11'h000, 1'b0, 1'b1);
        cycle(1'b1, 2'b11, 11'h000, 1'b0, 1'b0);
        cycle(1'b1, 2'b00, 11'h000, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 11'h000, 1'b1, 1'b1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        chk("flush_cnt", 32'(illegal_cnt), 32'd6);

        cycle(1'b1, 2'b10, T_ORR, 1'b0, 1'b0);
        cycle(1'b1, 2'b10, T_AND, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_ctrl", 32'(ALUControl), 32'hf);
        chk("async_cnt", 32'(illegal_cnt), 32'd0);
        q.delete(); mc = 0; mc2 = 0;
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b0, 2'b00, 11'h000, 1'b0, 1'b1);

        for (int k = 0; k < 400; k++) begin
            logic [10:0] op;
            case ($urandom_range(0, 4))
                0: op = T_ADD;
                1: op = T_SUB;
                2: op = T_AND;
                3: op = T_ORR;
                default: op = 11'($urandom);
            endcase
            cycle(1'($urandom), 2'($urandom), op, $urandom_range(0, 15) == 0, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
